dmem_line_ctrl: RTL

//  Off-chip data memory model/controller directly downstream of the L1 data cache.

---
 rtl/dmem_line_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/dmem_line_ctrl.sv
// Fixed-latency 256-bit line memory behind the L1 data cache miss interface.
// Optional access counters are enabled by defining DMEM_ACCESS_CNT_EN.
module dmem_line_ctrl #(
    parameter int unsigned LATENCY = 10,
    parameter int unsigned IDX_W   = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [31:0]  rd_cnt_o,
    output logic [31:0]  wr_cnt_o
`endif
);

    localparam int unsigned CNT_W = $clog2(LATENCY) + 1;
    localparam int unsigned DEPTH = 2 ** IDX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               wr_q, wr_d;
    logic [255:0]       wdata_q, wdata_d;
    logic               ack_q, ack_d;
    logic [255:0]       rdata_q, rdata_d;
    logic               commit;

    logic [255:0]       mem_q [DEPTH];

    logic               unused_addr;
    assign unused_addr = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        rdata_d = rdata_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    idx_d   = addr_i[5 +: IDX_W];
                    wr_d    = write_i;
                    wdata_d = data_i;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(LATENCY - 1)) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    commit  = 1'b1;
                    if (!wr_q) rdata_d = mem_q[idx_q];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    // Reset forces S_IDLE asynchronously, so an aborted write never reaches the array.
    always_ff @(posedge clk_i) begin
        if (commit && wr_q) mem_q[idx_q] <= wdata_q;
    end

    assign ack_o  = ack_q;
    assign data_o = rdata_q;

`ifdef DMEM_ACCESS_CNT_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (commit && !wr_q && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + 32'd1;
        if (commit &&  wr_q && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_cnt_o = rd_cnt_q;
    assign wr_cnt_o = wr_cnt_q;
`endif

endmodule
